// File: rtl/sd_ddr_burst_writer.sv
// rtl/sd_ddr_burst_writer.sv - packs SD read words into DDR beats and writes them out as AXI4 INCR bursts
module sd_ddr_burst_writer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DDR_DATA_WIDTH = 256,
    parameter int DDR_STRB_WIDTH = DDR_DATA_WIDTH / 8,
    parameter int ID_WIDTH       = 8,
    parameter int IN_WIDTH       = 16,
    parameter int BURST_LEN      = 16,
    parameter int FIFO_DEPTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     wr_base_addr,
    input  logic                      wr_en,
    input  logic [IN_WIDTH-1:0]       wrdata,
    input  logic                      wrlast,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [ID_WIDTH-1:0]       model_awid,
    output logic [ADDR_WIDTH-1:0]     model_awaddr,
    output logic [7:0]                model_awlen,
    output logic [2:0]                model_awsize,
    output logic [1:0]                model_awburst,
    output logic                      model_awlock,
    output logic [3:0]                model_awcache,
    output logic [2:0]                model_awprot,
    output logic                      model_awvalid,
    input  logic                      model_awready,
    output logic [DDR_DATA_WIDTH-1:0] model_wdata,
    output logic [DDR_STRB_WIDTH-1:0] model_wstrb,
    output logic                      model_wlast,
    output logic                      model_wvalid,
    input  logic                      model_wready,
    input  logic [ID_WIDTH-1:0]       model_bid,
    input  logic [1:0]                model_bresp,
    input  logic                      model_bvalid,
    output logic                      model_bready
);

    localparam int WPB     = DDR_DATA_WIDTH / IN_WIDTH;
    localparam int PC_W    = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int BPW     = IN_WIDTH / 8;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int LEN_W   = 9;
    localparam int ENTRY_W = DDR_DATA_WIDTH + DDR_STRB_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BURST_LEN * DDR_STRB_WIDTH - 1);
    localparam logic [CNT_W-1:0]      BURST_CNT  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]      DEPTH_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [DDR_DATA_WIDTH-1:0] pack_data_q, pack_data_d;
    logic [PC_W-1:0]           pack_cnt_q, pack_cnt_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [LEN_W-1:0]          beat_q, beat_d;
    logic                      awvalid_q, awvalid_d;
    logic                      bready_q, bready_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      flush_q, flush_d;

    logic [ENTRY_W-1:0]        fifo_mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0]        fifo_head;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      w_active;
    logic                      pop;
    logic                      accept;
    logic                      push_req;
    logic                      push_ok;
    logic [DDR_DATA_WIDTH-1:0] push_data;
    logic [DDR_STRB_WIDTH-1:0] push_strb;
    logic                      unused_bid;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_CNT);
    assign fifo_head  = fifo_mem[rd_ptr_q];
    assign w_active   = (state_q == ST_W) && !fifo_empty;
    assign pop        = w_active && model_wready;
    assign unused_bid = ^model_bid;

    // Next-state logic: word packing, beat FIFO bookkeeping and the burst FSM
    always_comb begin
        state_d     = state_q;
        pack_data_d = pack_data_q;
        pack_cnt_d  = pack_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        addr_d      = addr_q;
        len_d       = len_q;
        beat_d      = beat_q;
        awvalid_d   = awvalid_q;
        bready_d    = bready_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        flush_d     = flush_q;
        push_req    = 1'b0;
        push_data   = pack_data_q;
        push_strb   = '0;

        // Words after wrlast are ignored until the done pulse has gone by
        accept = wr_en && !flush_q && (state_q != ST_DONE);

        if (accept) begin
            if (!busy_q) begin
                busy_d = 1'b1;
                addr_d = wr_base_addr & ~ALIGN_MASK;
            end
            push_data[IN_WIDTH*pack_cnt_q +: IN_WIDTH] = wrdata;
            if (wrlast || (pack_cnt_q == PC_W'(WPB - 1))) begin
                push_req    = 1'b1;
                pack_data_d = '0;
                pack_cnt_d  = '0;
                for (int i = 0; i < DDR_STRB_WIDTH; i++) begin
                    push_strb[i] = (i < (int'(pack_cnt_q) + 1) * BPW);
                end
                if (wrlast) begin
                    flush_d = 1'b1;
                end
            end else begin
                pack_data_d = push_data;
                pack_cnt_d  = pack_cnt_q + PC_W'(1);
            end
        end

        // A beat that finds the FIFO full is lost; the stream itself keeps going
        push_ok = push_req && !fifo_full;
        if (push_req && fifo_full) begin
            err_d = 1'b1;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if ((count_q >= BURST_CNT) || (flush_q && !fifo_empty)) begin
                    len_d     = (count_q >= BURST_CNT) ? LEN_W'(BURST_LEN) : LEN_W'(count_q);
                    awvalid_d = 1'b1;
                    state_d   = ST_AW;
                end else if (flush_q && fifo_empty) begin
                    // Tail beat was dropped on overflow: nothing left to write
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_AW: begin
                if (model_awready) begin
                    awvalid_d = 1'b0;
                    beat_d    = '0;
                    state_d   = ST_W;
                end
            end
            ST_W: begin
                if (pop) begin
                    if (beat_q == len_q - LEN_W'(1)) begin
                        bready_d = 1'b1;
                        state_d  = ST_B;
                    end else begin
                        beat_d = beat_q + LEN_W'(1);
                    end
                end
            end
            ST_B: begin
                if (model_bvalid && bready_q) begin
                    bready_d = 1'b0;
                    if (model_bresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                    addr_d = addr_q + ADDR_WIDTH'(len_q) * ADDR_WIDTH'(DDR_STRB_WIDTH);
                    if (flush_q && fifo_empty) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b0;
                flush_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All control state, with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pack_data_q <= '0;
            pack_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            awvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pack_data_q <= pack_data_d;
            pack_cnt_q  <= pack_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            awvalid_q   <= awvalid_d;
            bready_q    <= bready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            flush_q     <= flush_d;
        end
    end

    // Beat storage: strobe in the upper bits, data below; contents need no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= {push_strb, push_data};
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign model_awid    = '0;
    assign model_awaddr  = addr_q;
    assign model_awlen   = 8'(len_q - LEN_W'(1));
    assign model_awsize  = 3'($clog2(DDR_STRB_WIDTH));
    assign model_awburst = 2'b01;
    assign model_awlock  = 1'b0;
    assign model_awcache = 4'b0011;
    assign model_awprot  = 3'b000;
    assign model_awvalid = awvalid_q;
    assign model_wvalid  = w_active;
    assign model_wdata   = w_active ? fifo_head[DDR_DATA_WIDTH-1:0] : '0;
    assign model_wstrb   = w_active ? fifo_head[ENTRY_W-1:DDR_DATA_WIDTH] : '0;
    assign model_wlast   = w_active && (beat_q == len_q - LEN_W'(1));
    assign model_bready  = bready_q;

endmodule

// File: tb/tb_sd_ddr_burst_writer.sv
// tb/tb_sd_ddr_burst_writer.sv - directed self-checking bench for sd_ddr_burst_writer
`timescale 1ns/1ps
module tb_sd_ddr_burst_writer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  wr_base_addr = '0;
    logic         wr_en = 1'b0;
    logic [15:0]  wrdata = '0;
    logic         wrlast = 1'b0;
    logic         busy, done, err;
    logic [7:0]   model_awid;
    logic [31:0]  model_awaddr;
    logic [7:0]   model_awlen;
    logic [2:0]   model_awsize;
    logic [1:0]   model_awburst;
    logic         model_awlock;
    logic [3:0]   model_awcache;
    logic [2:0]   model_awprot;
    logic         model_awvalid;
    logic         model_awready = 1'b0;
    logic [255:0] model_wdata;
    logic [31:0]  model_wstrb;
    logic         model_wlast;
    logic         model_wvalid;
    logic         model_wready = 1'b0;
    logic [7:0]   model_bid = '0;
    logic [1:0]   model_bresp = '0;
    logic         model_bvalid = 1'b0;
    logic         model_bready;

    always #5 clk = ~clk;

    sd_ddr_burst_writer dut (
        .clk(clk), .rst_n(rst_n), .wr_base_addr(wr_base_addr), .wr_en(wr_en),
        .wrdata(wrdata), .wrlast(wrlast), .busy(busy), .done(done), .err(err),
        .model_awid(model_awid), .model_awaddr(model_awaddr), .model_awlen(model_awlen),
        .model_awsize(model_awsize), .model_awburst(model_awburst), .model_awlock(model_awlock),
        .model_awcache(model_awcache), .model_awprot(model_awprot), .model_awvalid(model_awvalid),
        .model_awready(model_awready), .model_wdata(model_wdata), .model_wstrb(model_wstrb),
        .model_wlast(model_wlast), .model_wvalid(model_wvalid), .model_wready(model_wready),
        .model_bid(model_bid), .model_bresp(model_bresp), .model_bvalid(model_bvalid),
        .model_bready(model_bready)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   ready_mode = 0;
    int   bad_burst = -1;
    int   b_owed = 0;
    int   b_idx = 0;
    logic b_fired = 1'b0;
    int   aw_out = 0;
    int   order_viol = 0;
    int   done_events = 0;
    int   done_hi = 0;
    int   done_cyc = 0;
    int   last_b_cyc = 0;
    logic done_prev = 1'b0;

    logic [31:0]  aw_addr_log[$];
    logic [7:0]   aw_len_log[$];
    logic [255:0] w_data_log[$];
    logic [31:0]  w_strb_log[$];
    logic         w_last_log[$];

    // DDR slave: drive readies/B on the falling edge, log handshakes just after it
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_bvalid = 1'b0;
                b_owed = 0; b_idx = 0; aw_out = 0; b_fired = 1'b0; done_prev = 1'b0;
            end else begin
                if (b_fired) model_bvalid = 1'b0;
                if (!model_bvalid && b_owed > 0) begin
                    model_bvalid = 1'b1;
                    model_bresp = (b_idx == bad_burst) ? 2'b10 : 2'b00;
                end
                case (ready_mode)
                    1: begin
                        model_awready = 1'($urandom_range(0, 1));
                        model_wready  = 1'($urandom_range(0, 1));
                    end
                    2: begin model_awready = 1'b1; model_wready = 1'b0; end
                    default: begin model_awready = 1'b1; model_wready = 1'b1; end
                endcase
            end
            #1;
            b_fired = 1'b0;
            if (rst_n) begin
                if (model_bvalid && model_bready) begin
                    b_fired = 1'b1; b_owed--; b_idx++; last_b_cyc = cyc;
                end
                if (model_wvalid && aw_out == 0) order_viol++;
                if (model_awvalid && model_awready) begin
                    aw_addr_log.push_back(model_awaddr);
                    aw_len_log.push_back(model_awlen);
                    aw_out++;
                end
                if (model_wvalid && model_wready) begin
                    w_data_log.push_back(model_wdata);
                    w_strb_log.push_back(model_wstrb);
                    w_last_log.push_back(model_wlast);
                    if (model_wlast) begin aw_out--; b_owed++; end
                end
                if (done && !done_prev) begin done_events++; done_cyc = cyc; end
                if (done) done_hi++;
                done_prev = done;
            end
        end
    end

    function automatic logic [255:0] exp_beat(input int b, input int n);
        logic [255:0] v = '0;
        for (int k = 0; k < 16; k++) if (b * 16 + k < n) v[16*k +: 16] = 16'(b * 16 + k);
        return v;
    endfunction

    function automatic logic [31:0] exp_strb(input int b, input int n);
        logic [31:0] s = '0;
        for (int k = 0; k < 16; k++) if (b * 16 + k < n) s[2*k +: 2] = 2'b11;
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; wr_en = 1'b0; wrlast = 1'b0; wrdata = '0;
        repeat (2) @(negedge clk);
        aw_addr_log.delete(); aw_len_log.delete();
        w_data_log.delete(); w_strb_log.delete(); w_last_log.delete();
        done_events = 0; done_hi = 0; order_viol = 0;
        rst_n = 1'b1;
    endtask

    task automatic send_words(input int n, input int gap, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_base_addr = base; wr_en = 1'b1; wrdata = 16'(i); wrlast = (i == n - 1);
            for (int g = 1; g < gap; g++) begin
                @(negedge clk);
                wr_en = 1'b0; wrlast = 1'b0;
            end
        end
        @(negedge clk);
        wr_en = 1'b0; wrlast = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int start;
        int t;
        start = done_events;
        t = 0;
        while (done_events == start && t < budget) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (done_events == start) begin
            n_bad++;
            $display("FAIL %s_done_timeout: done not seen in %0d cycles, required 1 pulse", nm, budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if ({busy, done, err} !== 3'b000) begin n_bad++; $display("FAIL rst_status: got %b required 000", {busy, done, err}); end
        n_cmp++; if ({model_awvalid, model_wvalid, model_bready} !== 3'b000) begin n_bad++; $display("FAIL rst_valids: got %b required 000", {model_awvalid, model_wvalid, model_bready}); end
    endtask

    task automatic test_single_burst();
        int bad;
        do_reset();
        ready_mode = 0;
        send_words(256, 1, 32'h1000_0000);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL t1_busy_mid: got %b required 1", busy); end
        wait_done(500, "t1");
        n_cmp++; if (aw_addr_log.size() != 1) begin n_bad++; $display("FAIL t1_aw_count: got %0d required 1", aw_addr_log.size()); end
        n_cmp++; if (aw_addr_log[0] !== 32'h1000_0000) begin n_bad++; $display("FAIL t1_awaddr: got %h required 10000000", aw_addr_log[0]); end
        n_cmp++; if (aw_len_log[0] !== 8'd15) begin n_bad++; $display("FAIL t1_awlen: got %0d required 15", aw_len_log[0]); end
        n_cmp++; if ({model_awsize, model_awburst, model_awcache, model_awlock, model_awprot, model_awid} !== {3'd5, 2'b01, 4'b0011, 1'b0, 3'b000, 8'h00})
            begin n_bad++; $display("FAIL t1_aw_consts: got size %0d burst %b cache %b", model_awsize, model_awburst, model_awcache); end
        n_cmp++; if (w_data_log.size() != 16) begin n_bad++; $display("FAIL t1_w_count: got %0d required 16", w_data_log.size()); end
        n_cmp++; if (w_data_log[0][31:0] !== 32'h0001_0000) begin n_bad++; $display("FAIL t1_beat0_words: got %h required 00010000", w_data_log[0][31:0]); end
        bad = 0;
        for (int b = 0; b < w_data_log.size(); b++) begin
            if (w_data_log[b] !== exp_beat(b, 256) || w_strb_log[b] !== 32'hFFFF_FFFF || w_last_log[b] !== (b == 15)) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL t1_beats: %0d bad beats, required 0", bad); end
        n_cmp++; if (done_cyc - last_b_cyc != 1) begin n_bad++; $display("FAIL t1_done_latency: got %0d cycles required 1", done_cyc - last_b_cyc); end
        n_cmp++; if (done_hi != 1) begin n_bad++; $display("FAIL t1_done_width: got %0d cycles required 1", done_hi); end
        n_cmp++; if ({busy, err} !== 2'b00) begin n_bad++; $display("FAIL t1_end_status: got busy/err %b required 00", {busy, err}); end
    endtask

    task automatic test_partial_beat();
        int bad;
        do_reset();
        ready_mode = 0;
        send_words(40, 1, 32'h1000_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wrdata = 16'hDEAD; wrlast = (i == 2);
        end
        @(negedge clk);
        wr_en = 1'b0; wrlast = 1'b0;
        wait_done(500, "t2");
        n_cmp++; if (aw_len_log.size() != 1 || aw_len_log[0] !== 8'd2) begin n_bad++; $display("FAIL t2_awlen: got %0d bursts, len %0d, required 1 burst len 2", aw_len_log.size(), aw_len_log[0]); end
        n_cmp++; if (w_data_log.size() != 3) begin n_bad++; $display("FAIL t2_w_count: got %0d required 3", w_data_log.size()); end
        n_cmp++; if (w_strb_log[2] !== 32'h0000_FFFF) begin n_bad++; $display("FAIL t2_tail_strb: got %h required 0000ffff", w_strb_log[2]); end
        n_cmp++; if (w_data_log[2][255:128] !== 128'h0) begin n_bad++; $display("FAIL t2_tail_upper: got %h required 0", w_data_log[2][255:128]); end
        bad = 0;
        for (int b = 0; b < w_data_log.size(); b++) if (w_data_log[b] !== exp_beat(b, 40)) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL t2_data: %0d bad beats, required 0", bad); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL t2_ignored_words: busy %b required 0", busy); end
    endtask

    task automatic test_back_to_back();
        int bad;
        do_reset();
        ready_mode = 0;
        send_words(512, 1, 32'h2000_0010);
        wait_done(500, "t3");
        n_cmp++; if (aw_addr_log.size() != 2) begin n_bad++; $display("FAIL t3_aw_count: got %0d required 2", aw_addr_log.size()); end
        n_cmp++; if (aw_addr_log[0] !== 32'h2000_0000 || aw_addr_log[1] !== 32'h2000_0200)
            begin n_bad++; $display("FAIL t3_awaddr: got %h %h required 20000000 20000200", aw_addr_log[0], aw_addr_log[1]); end
        n_cmp++; if (aw_len_log[0] !== 8'd15 || aw_len_log[1] !== 8'd15) begin n_bad++; $display("FAIL t3_awlen: got %0d %0d required 15 15", aw_len_log[0], aw_len_log[1]); end
        bad = 0;
        for (int b = 0; b < w_data_log.size(); b++) if (w_data_log[b] !== exp_beat(b, 512)) bad++;
        n_cmp++; if (bad != 0 || w_data_log.size() != 32) begin n_bad++; $display("FAIL t3_data: %0d bad of %0d beats, required 0 of 32", bad, w_data_log.size()); end
    endtask

    task automatic test_stalls();
        int bad;
        do_reset();
        ready_mode = 1;
        send_words(300, 4, 32'h3000_0000);
        wait_done(3000, "t4");
        ready_mode = 0;
        n_cmp++; if (w_data_log.size() != 19) begin n_bad++; $display("FAIL t4_w_count: got %0d required 19", w_data_log.size()); end
        bad = 0;
        for (int b = 0; b < w_data_log.size(); b++) if (w_data_log[b] !== exp_beat(b, 300) || w_strb_log[b] !== exp_strb(b, 300)) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL t4_data: %0d bad beats, required 0", bad); end
        n_cmp++; if (aw_len_log.size() != 2 || aw_len_log[0] !== 8'd15 || aw_len_log[1] !== 8'd2)
            begin n_bad++; $display("FAIL t4_awlen: got %0d bursts, lens %0d %0d, required 15 2", aw_len_log.size(), aw_len_log[0], aw_len_log[1]); end
        n_cmp++; if (order_viol != 0) begin n_bad++; $display("FAIL t4_w_before_aw: got %0d cycles required 0", order_viol); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL t4_err: got %b required 0", err); end
    endtask

    task automatic test_bresp_error();
        do_reset();
        ready_mode = 0;
        bad_burst = 1;
        send_words(768, 1, 32'h4000_0000);
        wait_done(500, "t5");
        n_cmp++; if (aw_addr_log.size() != 3 || aw_addr_log[2] !== 32'h4000_0400)
            begin n_bad++; $display("FAIL t5_bursts: got %0d bursts, last %h, required 3 last 40000400", aw_addr_log.size(), aw_addr_log[2]); end
        repeat (5) @(negedge clk);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL t5_err_sticky: got %b required 1", err); end
        n_cmp++; if (done_events != 1) begin n_bad++; $display("FAIL t5_done: got %0d pulses required 1", done_events); end
        bad_burst = -1;
    endtask

    task automatic test_overflow_reset();
        int bad;
        do_reset();
        ready_mode = 2;
        send_words(560, 1, 32'h5000_0000);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL t6_overflow_err: got %b required 1", err); end
        n_cmp++; if (model_wvalid !== 1'b1) begin n_bad++; $display("FAIL t6_w_stalled: wvalid %b required 1", model_wvalid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({model_awvalid, model_wvalid, busy, err} !== 4'b0000)
            begin n_bad++; $display("FAIL t6_mid_reset: got aw/w/busy/err %b required 0000", {model_awvalid, model_wvalid, busy, err}); end
        ready_mode = 0;
        do_reset();
        send_words(40, 1, 32'h5000_0000);
        wait_done(500, "t6");
        n_cmp++; if (w_data_log.size() != 3 || aw_len_log.size() != 1) begin n_bad++; $display("FAIL t6_fifo_flushed: got %0d beats %0d bursts required 3 and 1", w_data_log.size(), aw_len_log.size()); end
        bad = 0;
        for (int b = 0; b < w_data_log.size(); b++) if (w_data_log[b] !== exp_beat(b, 40)) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL t6_data: %0d bad beats, required 0", bad); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_partial_beat();
        test_back_to_back();
        test_stalls();
        test_bresp_error();
        test_overflow_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
